// File: rtl/instr_fetch_unit.sv
// Program-counter / fetch stage ahead of the microinstruction RAM. It issues addresses,
// tags returned words with their PC and executes decoder redirects using a return stack.
module instr_fetch_unit #(
    parameter int                   ADDR_SIZE   = 11,
    parameter int                   RAM_WIDTH   = 22,
    parameter int                   STACK_DEPTH = 8,
    parameter logic [ADDR_SIZE-1:0] RESET_PC    = '0
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 run,
    output logic [ADDR_SIZE-1:0] mem_addr,
    output logic                 mem_rd_enb,
    input  logic [RAM_WIDTH-1:0] mem_data,
    output logic [RAM_WIDTH-1:0] instr_out,
    output logic [ADDR_SIZE-1:0] instr_pc,
    output logic                 instr_valid,
    input  logic                 instr_ready,
    input  logic                 redir_valid,
    input  logic [1:0]           redir_type,
    input  logic [ADDR_SIZE-1:0] redir_arg,
    output logic                 stk_ovf,
    output logic                 stk_unf
);

    localparam logic [1:0] RT_ABS  = 2'b00;
    localparam logic [1:0] RT_REL  = 2'b01;
    localparam logic [1:0] RT_CALL = 2'b10;
    localparam logic [1:0] RT_RET  = 2'b11;

    localparam int SPW  = $clog2(STACK_DEPTH + 1);
    localparam int IDXW = $clog2(STACK_DEPTH);

    logic [ADDR_SIZE-1:0] fetch_pc;
    logic [ADDR_SIZE-1:0] stack [STACK_DEPTH];
    logic [SPW-1:0]       sp;
    logic [SPW-1:0]       sp_m1;
    logic                 stack_empty;
    logic                 stack_full;
    logic                 take;
    logic                 push;
    logic [ADDR_SIZE-1:0] target;

    always_comb begin
        sp_m1       = sp - SPW'(1);
        stack_empty = (sp == '0);
        stack_full  = (sp == SPW'(STACK_DEPTH));
        take        = redir_valid & instr_valid & instr_ready;
        push        = take & (redir_type == RT_CALL) & ~stack_full;
        // Offsets are ADDR_SIZE wide, so sign extension is the identity and the add wraps.
        case (redir_type)
            RT_ABS:  target = redir_arg;
            RT_REL,
            RT_CALL: target = instr_pc + redir_arg;
            default: target = stack_empty ? RESET_PC : stack[sp_m1[IDXW-1:0]];
        endcase
    end

    assign mem_rd_enb = rst_n & run & (~instr_valid | instr_ready);
    assign mem_addr   = take ? target : fetch_pc;
    assign instr_out  = mem_data;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            fetch_pc    <= RESET_PC;
            instr_pc    <= '0;
            instr_valid <= 1'b0;
            sp          <= '0;
            stk_ovf     <= 1'b0;
            stk_unf     <= 1'b0;
        end else begin
            if (take) begin
                case (redir_type)
                    RT_CALL: begin
                        if (stack_full) stk_ovf <= 1'b1;
                        else            sp      <= sp + SPW'(1);
                    end
                    RT_RET: begin
                        if (stack_empty) stk_unf <= 1'b1;
                        else             sp      <= sp_m1;
                    end
                    default: ;
                endcase
            end
            if (mem_rd_enb) begin
                instr_valid <= 1'b1;
                instr_pc    <= mem_addr;
                fetch_pc    <= mem_addr + ADDR_SIZE'(1);
            end else begin
                // Only reachable with run=0 (or a stall): retire the consumed word, keep the PC.
                if (instr_valid && instr_ready) instr_valid <= 1'b0;
                if (take)                       fetch_pc    <= target;
            end
        end
    end

    // Entries above sp are dead, so the storage itself needs no reset.
    always_ff @(posedge clk) begin
        if (push) stack[sp[IDXW-1:0]] <= instr_pc + ADDR_SIZE'(1);
    end

endmodule

// File: tb/tb_instr_fetch_unit.sv
// Directed bench for instr_fetch_unit with a behavioural 1-cycle registered program RAM.
module tb_instr_fetch_unit;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        run;
    logic [10:0] mem_addr;
    logic        mem_rd_enb;
    logic [21:0] mem_data = '0;
    logic [21:0] instr_out;
    logic [10:0] instr_pc;
    logic        instr_valid;
    logic        instr_ready;
    logic        redir_valid;
    logic [1:0]  redir_type;
    logic [10:0] redir_arg;
    logic        stk_ovf;
    logic        stk_unf;

    int n_assert = 0;
    int n_fail   = 0;

    instr_fetch_unit dut (
        .clk(clk), .rst_n(rst_n), .run(run),
        .mem_addr(mem_addr), .mem_rd_enb(mem_rd_enb), .mem_data(mem_data),
        .instr_out(instr_out), .instr_pc(instr_pc), .instr_valid(instr_valid),
        .instr_ready(instr_ready), .redir_valid(redir_valid), .redir_type(redir_type),
        .redir_arg(redir_arg), .stk_ovf(stk_ovf), .stk_unf(stk_unf)
    );

    always #5 clk = ~clk;

    function automatic logic [21:0] word(input logic [10:0] a);
        return {a ^ 11'h2A5, a};
    endfunction

    always @(posedge clk) if (mem_rd_enb) mem_data <= word(mem_addr);

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic redir(input logic [1:0] t, input logic [10:0] a);
        redir_valid = 1'b1;
        redir_type  = t;
        redir_arg   = a;
    endtask

    task automatic chk_word(input string tag, input logic [10:0] pc);
        chk({tag, "_valid"}, 32'(instr_valid), 32'd1);
        chk({tag, "_pc"},    32'(instr_pc),    32'(pc));
        chk({tag, "_data"},  32'(instr_out),   32'(word(pc)));
    endtask

    initial begin
        rst_n = 1'b0; run = 1'b0; instr_ready = 1'b0;
        redir_valid = 1'b0; redir_type = 2'b00; redir_arg = '0;
        tick(); tick();
        chk("rst_valid", 32'(instr_valid), 0);
        chk("rst_rd_enb", 32'(mem_rd_enb), 0);
        chk("rst_pc", 32'(instr_pc), 0);
        chk("rst_addr", 32'(mem_addr), 0);
        chk("rst_flags", {30'd0, stk_ovf, stk_unf}, 0);

        // Sequential fetch from reset
        rst_n = 1'b1; run = 1'b1; instr_ready = 1'b1; #1;
        chk("seq_first_rd", 32'(mem_rd_enb), 1);
        chk("seq_first_addr", 32'(mem_addr), 0);
        chk("seq_first_valid", 32'(instr_valid), 0);
        for (int i = 0; i <= 5; i++) begin
            tick();
            chk_word("seq", 11'(i));
            chk("seq_addr", 32'(mem_addr), 32'(i + 1));
        end

        // Stall with instr_pc=5
        instr_ready = 1'b0; #1;
        chk("stall_rd", 32'(mem_rd_enb), 0);
        for (int i = 0; i < 2; i++) begin
            tick();
            chk_word("stall_hold", 11'd5);
            chk("stall_rd_hold", 32'(mem_rd_enb), 0);
        end
        redir(2'b00, 11'h100); #1;
        tick();
        chk_word("ignored_redir", 11'd5);
        chk("ignored_addr", 32'(mem_addr), 6);
        redir_valid = 1'b0; instr_ready = 1'b1; #1;
        chk("unstall_addr", 32'(mem_addr), 6);
        for (int i = 6; i <= 14; i++) begin
            tick();
            chk_word("seq2", 11'(i));
        end

        // CALL at 14 -> 200, RET at 207 -> 15
        redir(2'b10, 11'd186); #1;
        chk("call_addr", 32'(mem_addr), 200);
        tick();
        redir_valid = 1'b0;
        chk_word("call_tgt", 11'd200);
        for (int i = 201; i <= 207; i++) begin
            tick();
            chk("call_body_pc", 32'(instr_pc), 32'(i));
        end
        redir(2'b11, 11'd0); #1;
        chk("ret_addr", 32'(mem_addr), 15);
        tick();
        chk_word("ret_tgt", 11'd15);

        // ABS to 0x7FF then wrap, REL -3 at pc 3
        redir(2'b00, 11'h7FF); #1;
        tick();
        redir_valid = 1'b0;
        chk_word("abs_tgt", 11'h7FF);
        for (int i = 0; i <= 3; i++) begin
            tick();
            chk_word("wrap", 11'(i));
        end
        redir(2'b01, 11'h7FD); #1;
        chk("rel_addr", 32'(mem_addr), 0);
        tick();
        redir_valid = 1'b0;
        chk_word("rel_tgt", 11'd0);
        tick();
        chk("pc1", 32'(instr_pc), 1);

        // run=0 drains and holds
        run = 1'b0; #1;
        chk("halt_rd", 32'(mem_rd_enb), 0);
        tick();
        chk("halt_valid", 32'(instr_valid), 0);
        chk("halt_addr", 32'(mem_addr), 2);
        tick();
        chk("halt_valid2", 32'(instr_valid), 0);
        run = 1'b1; #1;
        tick();
        chk_word("resume", 11'd2);

        // Redirect taken while run=0
        run = 1'b0; redir(2'b00, 11'h040); #1;
        chk("halt_redir_rd", 32'(mem_rd_enb), 0);
        tick();
        redir_valid = 1'b0;
        chk("halt_redir_valid", 32'(instr_valid), 0);
        chk("halt_redir_addr", 32'(mem_addr), 32'h40);
        run = 1'b1; #1;
        tick();
        chk_word("halt_redir_tgt", 11'h040);

        // Nine nested CALLs (+0x10 each) then nine RETs
        for (int k = 0; k <= 8; k++) begin
            redir(2'b10, 11'h010); #1;
            chk("ncall_addr", 32'(mem_addr), 32'(32'h40 + 32'h10 * (k + 1)));
            tick();
            chk("ncall_pc", 32'(instr_pc), 32'(32'h40 + 32'h10 * (k + 1)));
            chk("ncall_ovf", 32'(stk_ovf), 32'(k == 8));
        end
        for (int j = 0; j <= 8; j++) begin
            redir(2'b11, 11'd0); #1;
            tick();
            chk("nret_pc", 32'(instr_pc), (j < 8) ? 32'(32'h40 + 32'h10 * (7 - j) + 1) : 32'd0);
            chk("nret_unf", 32'(stk_unf), 32'(j == 8));
        end
        chk("nret_ovf_sticky", 32'(stk_ovf), 1);

        // Three CALLs, stall, reset mid-stall
        for (int k = 1; k <= 3; k++) begin
            redir(2'b10, 11'h020); #1;
            tick();
            chk("rcall_pc", 32'(instr_pc), 32'(32'h20 * k));
        end
        redir_valid = 1'b0; instr_ready = 1'b0; #1;
        tick();
        chk_word("rstall", 11'h060);
        rst_n = 1'b0; #1;
        chk("arst_valid", 32'(instr_valid), 0);
        chk("arst_rd", 32'(mem_rd_enb), 0);
        chk("arst_flags", {30'd0, stk_ovf, stk_unf}, 0);
        chk("arst_pc", 32'(instr_pc), 0);
        tick();
        rst_n = 1'b1; instr_ready = 1'b1; #1;
        chk("rerun_addr", 32'(mem_addr), 0);
        chk("rerun_rd", 32'(mem_rd_enb), 1);
        tick();
        chk_word("rerun", 11'd0);
        redir(2'b11, 11'd0); #1;
        chk("unf_ret_addr", 32'(mem_addr), 0);
        tick();
        redir_valid = 1'b0;
        chk("unf_ret_pc", 32'(instr_pc), 0);
        chk("unf_flag", 32'(stk_unf), 1);
        chk("unf_ovf_clear", 32'(stk_ovf), 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule
